formula_loader: RTL and testbench

- Writer side of the formula checker's clause-register interface.
- Accepts clauses from the host/controller over a valid/ready stream and writes each clause's integer and boolean coefficients to the clause registers, one index at a time.
- Builds the per-clause enable mask the checker uses to ignore unused clauses.
- Signals completion so the MCMC controller can start checking assignments.

---
 rtl/formula_loader.sv | 161 ++++++++++++++++
 tb/tb_formula_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_loader.sv
// rtl/formula_loader.sv - clause-register writer for the formula checker; optional zero fill via FORMULA_LOADER_ZERO_FILL_EN
module formula_loader #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
    localparam int NI = 2 ** MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int NB = 2 ** MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    localparam int NC = 2 ** MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int CI = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int IW = (NI + 1) * MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
    localparam int BW = NB * MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT
) (
    input  logic          in_clk,
    input  logic          in_reset,
    input  logic          in_start,
    input  logic [CI:0]   in_number_of_clauses,
    input  logic          in_clause_valid,
    output logic          out_clause_ready,
    input  logic [IW-1:0] in_clause_coefficients_integer,
    input  logic [BW-1:0] in_clause_coefficients_boolean,
    output logic [IW-1:0] out_clause_coefficients_integer,
    output logic [BW-1:0] out_clause_coefficients_boolean,
    output logic [CI-1:0] out_clause_index,
    output logic          out_clause_write,
    output logic [NC-1:0] out_clause_enable,
    output logic          out_busy,
    output logic          out_done,
    output logic          out_error
);

    localparam logic [CI:0] NC_CNT = (CI + 1)'(NC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
`ifdef FORMULA_LOADER_ZERO_FILL_EN
        S_FILL   = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CI:0]   r_count;
    logic [CI-1:0] r_counter;
    logic [CI-1:0] r_index;
    logic [IW-1:0] r_int;
    logic [BW-1:0] r_bool;
    logic [NC-1:0] r_enable;
    logic          r_ready;
    logic          r_write;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          w_last;
    logic          w_legal;

    assign w_last  = ({1'b0, r_counter} == (r_count - 1'b1));
    assign w_legal = (in_number_of_clauses != '0) && (in_number_of_clauses <= NC_CNT);

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_counter <= '0;
            r_index   <= '0;
            r_int     <= '0;
            r_bool    <= '0;
            r_enable  <= '0;
            r_ready   <= 1'b0;
            r_write   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            r_error <= in_start && r_busy;
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        if (w_legal) begin
                            r_count   <= in_number_of_clauses;
                            r_enable  <= '0;
                            r_counter <= '0;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_ACCEPT;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (in_clause_valid && r_ready) begin
                        r_int   <= in_clause_coefficients_integer;
                        r_bool  <= in_clause_coefficients_boolean;
                        r_index <= r_counter;
                        r_write <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_enable[r_counter] <= 1'b1;
                    if (w_last) begin
`ifdef FORMULA_LOADER_ZERO_FILL_EN
                        if (r_count < NC_CNT) begin
                            r_index <= r_counter + 1'b1;
                            r_int   <= '0;
                            r_bool  <= '0;
                            r_write <= 1'b1;
                            r_state <= S_FILL;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
`else
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_counter <= r_counter + 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= S_ACCEPT;
                    end
                end
`ifdef FORMULA_LOADER_ZERO_FILL_EN
                // Zero writes run through the top index; mask bits stay clear.
                S_FILL: begin
                    if (&r_index) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_write <= 1'b1;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_clause_ready                = r_ready;
    assign out_clause_coefficients_integer = r_int;
    assign out_clause_coefficients_boolean = r_bool;
    assign out_clause_index                = r_index;
    assign out_clause_write                = r_write;
    assign out_clause_enable               = r_enable;
    assign out_busy                        = r_busy;
    assign out_done                        = r_done;
    assign out_error                       = r_error;

endmodule

// File: tb/tb_formula_loader.sv
// tb/tb_formula_loader.sv - scoreboard bench for formula_loader
module tb_formula_loader;

    logic        clk;
    logic        rst;
    logic        in_start;
    logic [2:0]  in_count;
    logic        in_valid;
    logic [11:0] in_int;
    logic [3:0]  in_bool;
    logic        out_ready;
    logic [11:0] out_int;
    logic [3:0]  out_bool;
    logic [1:0]  out_index;
    logic        out_write;
    logic [3:0]  out_enable;
    logic        out_busy;
    logic        out_done;
    logic        out_error;

    formula_loader dut (
        .in_clk                          (clk),
        .in_reset                        (rst),
        .in_start                        (in_start),
        .in_number_of_clauses            (in_count),
        .in_clause_valid                 (in_valid),
        .out_clause_ready                (out_ready),
        .in_clause_coefficients_integer  (in_int),
        .in_clause_coefficients_boolean  (in_bool),
        .out_clause_coefficients_integer (out_int),
        .out_clause_coefficients_boolean (out_bool),
        .out_clause_index                (out_index),
        .out_clause_write                (out_write),
        .out_clause_enable               (out_enable),
        .out_busy                        (out_busy),
        .out_done                        (out_done),
        .out_error                       (out_error)
    );

    typedef struct {
        logic [1:0]  idx;
        logic [11:0] iw;
        logic [3:0]  bw;
        bit          fill;
    } exp_t;

    exp_t       sb[$];
    int         wr_cycles[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [3:0] exp_mask = '0;
    logic [1:0] next_idx = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write monitor: pops the scoreboard; mask must not yet show the bit being written.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_write) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write index=%0d int=%h", out_index, out_int);
                end else begin
                    e = sb.pop_front();
                    if (out_index !== e.idx || out_int !== e.iw || out_bool !== e.bw) begin
                        failures++;
                        $display("FAIL write_data got idx=%0d int=%h bool=%h want idx=%0d int=%h bool=%h",
                                 out_index, out_int, out_bool, e.idx, e.iw, e.bw);
                    end
                    checks++;
                    if (out_enable !== exp_mask) begin
                        failures++;
                        $display("FAIL mask_during_write got=%b want=%b", out_enable, exp_mask);
                    end
                    if (!e.fill) exp_mask[e.idx] = 1'b1;
                end
                wr_cycles.push_back(cyc);
            end
            if (out_done) done_cnt++;
            if (out_error) err_cnt++;
        end
    end

    task automatic do_start(input logic [2:0] n);
        in_start = 1'b1;
        in_count = n;
        if (n != 0 && n <= 4) begin
            next_idx = '0;
            exp_mask = '0;
        end
        @(posedge clk); #1;
        in_start = 1'b0;
    endtask

    task automatic send(input logic [11:0] iw, input logic [3:0] bw, input bit keep);
        int n = 0;
        in_valid = 1'b1;
        in_int   = iw;
        in_bool  = bw;
        while (!out_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout ready=%b want=1", out_ready);
            in_valid = 1'b0;
        end else begin
            sb.push_back('{next_idx, iw, bw, 1'b0});
            next_idx++;
            @(posedge clk); #1;
            if (!keep) in_valid = 1'b0;
        end
    endtask

    task automatic push_fill(input int count);
`ifdef FORMULA_LOADER_ZERO_FILL_EN
        for (int i = count; i < 4; i++) sb.push_back('{2'(i), 12'h000, 4'h0, 1'b1});
`else
        if (count < 0) sb.delete();
`endif
    endtask

    function automatic int fill_writes(input int count);
`ifdef FORMULA_LOADER_ZERO_FILL_EN
        return 4 - count;
`else
        return count - count;
`endif
    endfunction

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL done_timeout done_pulses=%0d want>=1", done_cnt - d0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_start = 1'b0; in_count = '0; in_valid = 1'b0; in_int = '0; in_bool = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_ready, out_write, out_busy, out_done, out_error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {out_ready, out_write, out_busy, out_done, out_error});
        end
        checks++;
        if ({out_int, out_bool, out_index, out_enable} !== 22'b0) begin
            failures++;
            $display("FAIL reset_data got int=%h bool=%h idx=%0d en=%b want all 0", out_int, out_bool, out_index, out_enable);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_load;
        int d0 = done_cnt;
        wr_cycles.delete();
        do_start(3'd4);
        checks++;
        if (out_busy !== 1'b1 || out_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_busy_ready got busy=%b ready=%b want 1 1", out_busy, out_ready);
        end
        for (int i = 0; i < 4; i++) send(12'(12'h111 * (i + 1)), 4'(i + 5), 1'b1);
        in_valid = 1'b0;
        push_fill(4);
        wait_done(d0);
        checks++;
        if (wr_cycles.size() != 4) begin
            failures++;
            $display("FAIL full_write_count got=%0d want=4", wr_cycles.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (wr_cycles[i] - wr_cycles[i-1] != 2) begin
                    failures++;
                    $display("FAIL full_spacing got=%0d want=2", wr_cycles[i] - wr_cycles[i-1]);
                end
            end
        end
        checks++;
        if (out_enable !== 4'b1111 || out_busy !== 1'b0 || done_cnt - d0 != 1 || sb.size() != 0) begin
            failures++;
            $display("FAIL full_end got en=%b busy=%b done=%0d pend=%0d want 1111 0 1 0",
                     out_enable, out_busy, done_cnt - d0, sb.size());
        end
    endtask

    task automatic test_gaps;
        int d0 = done_cnt;
        wr_cycles.delete();
        do_start(3'd2);
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                checks++;
                if (out_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL gap_ready got=%b want=1", out_ready);
                end
            end
            send(12'(12'hA50 + c), 4'(c + 9), 1'b0);
        end
        push_fill(2);
        wait_done(d0);
        checks++;
        if (wr_cycles.size() != 2 + fill_writes(2) || out_enable !== 4'b0011 || sb.size() != 0) begin
            failures++;
            $display("FAIL gaps_end got writes=%0d en=%b pend=%0d want %0d 0011 0",
                     wr_cycles.size(), out_enable, sb.size(), 2 + fill_writes(2));
        end
    endtask

    task automatic test_illegal;
        logic [2:0] bad[2] = '{3'd0, 3'd5};
        int e0 = err_cnt;
        wr_cycles.delete();
        for (int k = 0; k < 2; k++) begin
            do_start(bad[k]);
            checks++;
            if (out_error !== 1'b1 || out_busy !== 1'b0 || out_ready !== 1'b0) begin
                failures++;
                $display("FAIL illegal_%0d got err=%b busy=%b ready=%b want 1 0 0", bad[k], out_error, out_busy, out_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (out_error !== 1'b0) begin
                failures++;
                $display("FAIL illegal_pulse got=%b want=0", out_error);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_cycles.size() != 0 || out_enable !== 4'b0011 || err_cnt - e0 != 2) begin
            failures++;
            $display("FAIL illegal_end got writes=%0d en=%b errs=%0d want 0 0011 2", wr_cycles.size(), out_enable, err_cnt - e0);
        end
    endtask

    task automatic test_start_while_busy;
        int d0 = done_cnt;
        int e0 = err_cnt;
        do_start(3'd3);
        send(12'h0C1, 4'h1, 1'b0);
        in_start = 1'b1;
        in_count = 3'd1;
        @(posedge clk); #1;
        in_start = 1'b0;
        checks++;
        if (out_error !== 1'b1 || out_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_start got err=%b busy=%b want 1 1", out_error, out_busy);
        end
        send(12'h0C2, 4'h2, 1'b0);
        send(12'h0C3, 4'h3, 1'b0);
        push_fill(3);
        wait_done(d0);
        checks++;
        if (out_enable !== 4'b0111 || err_cnt - e0 != 1 || done_cnt - d0 != 1 || sb.size() != 0) begin
            failures++;
            $display("FAIL busy_end got en=%b errs=%0d done=%0d pend=%0d want 0111 1 1 0",
                     out_enable, err_cnt - e0, done_cnt - d0, sb.size());
        end
    endtask

    task automatic test_async_reset;
        int d0;
        do_start(3'd3);
        send(12'hD01, 4'h4, 1'b0);
        send(12'hD02, 4'h5, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_ready, out_write, out_busy, out_done, out_error, out_enable, out_index, out_int, out_bool} !== 27'b0) begin
            failures++;
            $display("FAIL async_reset got ready=%b wr=%b busy=%b en=%b idx=%0d int=%h want all 0",
                     out_ready, out_write, out_busy, out_enable, out_index, out_int);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_mask = '0;
        wr_cycles.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_cycles.size() != 0 || out_busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL post_reset got writes=%0d busy=%b pend=%0d want 0 0 0", wr_cycles.size(), out_busy, sb.size());
        end
        d0 = done_cnt;
        do_start(3'd1);
        send(12'hE0E, 4'hE, 1'b0);
        push_fill(1);
        wait_done(d0);
        checks++;
        if (wr_cycles.size() != 1 + fill_writes(1) || out_enable !== 4'b0001 || sb.size() != 0) begin
            failures++;
            $display("FAIL reload_end got writes=%0d en=%b pend=%0d want %0d 0001 0",
                     wr_cycles.size(), out_enable, sb.size(), 1 + fill_writes(1));
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_illegal();
        test_start_while_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
